// File: rtl/mlp_batch_sequencer_if.sv
// Bundle between the batch sequencer (slave side) and its host / MLP controller /
// label memory (master side).
// Handshake: go is a level accepted only in IDLE. mlp_start is a one-cycle request.
// mlp_done is a one-cycle completion that is honoured only while waiting. label_data
// is valid from the cycle after label_rd.
interface mlp_batch_sequencer_if;
    logic        go;
    logic        abort;
    logic [9:0]  first_idx;
    logic [9:0]  last_idx;
    logic        mlp_done;
    logic [3:0]  mlp_class;
    logic [3:0]  label_data;
    logic        mlp_start;
    logic [9:0]  test_num;
    logic        label_rd;
    logic [9:0]  label_addr;
    logic [10:0] correct_cnt;
    logic [10:0] total_cnt;
    logic        busy;
    logic        batch_done;
    logic        timeout_err;

    modport master (
        output go, abort, first_idx, last_idx, mlp_done, mlp_class, label_data,
        input  mlp_start, test_num, label_rd, label_addr, correct_cnt, total_cnt,
               busy, batch_done, timeout_err
    );

    modport slave (
        input  go, abort, first_idx, last_idx, mlp_done, mlp_class, label_data,
        output mlp_start, test_num, label_rd, label_addr, correct_cnt, total_cnt,
               busy, batch_done, timeout_err
    );
endinterface

// File: rtl/mlp_batch_sequencer.sv
// Runs the MLP over an inclusive range of test-sample indices and scores each class
// against the label memory. Define MLP_TIMEOUT_EN to enable the per-sample wait timeout.
module mlp_batch_sequencer #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                        clk,
    input  logic                        rst,
    mlp_batch_sequencer_if.slave        bus,
    output logic [2:0]                  dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_LABEL   = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state;
    logic [9:0]  cur_idx;
    logic [9:0]  end_idx;
    logic [3:0]  class_q;
    logic [10:0] correct_cnt;
    logic [10:0] total_cnt;

`ifdef MLP_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0] wait_cnt;
    logic           timeout_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_idx     <= '0;
            end_idx     <= '0;
            class_q     <= '0;
            correct_cnt <= '0;
            total_cnt   <= '0;
`ifdef MLP_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else if (bus.abort && state != S_IDLE) begin
            // Abort beats everything else; the results gathered so far are kept.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        cur_idx     <= bus.first_idx;
                        end_idx     <= bus.last_idx;
                        correct_cnt <= '0;
                        total_cnt   <= '0;
`ifdef MLP_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        state <= (bus.first_idx > bus.last_idx) ? S_FINISH : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef MLP_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mlp_done) begin
                        class_q <= bus.mlp_class;
                        state   <= S_LABEL;
                    end
`ifdef MLP_TIMEOUT_EN
                    // The sample still counts as completed, just never as correct.
                    else if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        total_cnt   <= total_cnt + 11'd1;
                        state       <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_LABEL: state <= S_COMPARE;
                S_COMPARE: begin
                    total_cnt <= total_cnt + 11'd1;
                    if (class_q == bus.label_data) correct_cnt <= correct_cnt + 11'd1;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    // Equality test rather than a range test so index 1023 ends cleanly.
                    if (cur_idx == end_idx) begin
                        state <= S_FINISH;
                    end else begin
                        cur_idx <= cur_idx + 10'd1;
                        state   <= S_LAUNCH;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.mlp_start   = (state == S_LAUNCH);
    assign bus.label_rd    = (state == S_LABEL);
    assign bus.batch_done  = (state == S_FINISH);
    assign bus.busy        = (state != S_IDLE);
    assign bus.test_num    = cur_idx;
    assign bus.label_addr  = cur_idx;
    assign bus.correct_cnt = correct_cnt;
    assign bus.total_cnt   = total_cnt;
    assign dbg_state       = state;
`ifdef MLP_TIMEOUT_EN
    assign bus.timeout_err = timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Directed bench for mlp_batch_sequencer with a behavioural MLP and label memory.
// Build with or without MLP_TIMEOUT_EN; the timeout scenario adapts to the build.
module tb_mlp_batch_sequencer;

    localparam int         TO         = 20;
    localparam int         LAT        = 10;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd4;

    // clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    always #5 clk = ~clk;

    mlp_batch_sequencer_if bus ();

    mlp_batch_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         busy_left = 0;
    int         skip_idx = -1;
    int         inject_req = 0;
    int         inject_ack = 0;
    logic [9:0] pend_idx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] label_of(input logic [9:0] i);
        return 4'(i % 10);
    endfunction

    // Index 2 is the one sample the model misclassifies.
    function automatic logic [3:0] class_of(input logic [9:0] i);
        return (i == 10'd2) ? 4'((i + 1) % 10) : label_of(i);
    endfunction

    // MLP / label-memory model plus test_num scoreboard, all on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            busy_left      = 0;
            bus.mlp_done   = 1'b0;
            bus.mlp_class  = 4'd0;
            bus.label_data = 4'd0;
        end else begin
            bus.mlp_done = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    bus.mlp_done  = 1'b1;
                    bus.mlp_class = class_of(pend_idx);
                end
            end
            if (inject_req != inject_ack) begin
                inject_ack    = inject_req;
                bus.mlp_done  = 1'b1;
                bus.mlp_class = 4'd0;
            end
            if (bus.mlp_start) begin
                start_cnt++;
                check("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("test_num", bus.test_num, exp_q.pop_front());
                pend_idx  = bus.test_num;
                busy_left = (int'(bus.test_num) == skip_idx) ? 0 : LAT;
            end
            if (bus.label_rd) bus.label_data = label_of(bus.label_addr);
            if (bus.batch_done) done_cnt++;
        end
    end

    // driver tasks
    task automatic start_batch(input logic [9:0] first, input logic [9:0] last);
        @(negedge clk);
        bus.first_idx = first;
        bus.last_idx  = last;
        bus.go        = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int cyc);
        cyc = 0;
        while (!bus.batch_done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_in_time"}, cyc < max, 1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int nstarts,
                              input int s0, input int max);
        int c;
        c = 0;
        while (!(dbg_state == st && start_cnt - s0 == nstarts) && c < max) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_state_reached"}, c < max, 1);
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {bus.mlp_start, bus.label_rd, bus.busy, bus.batch_done,
                               bus.timeout_err}, 0);
        check({tag, "_cnts"}, {bus.correct_cnt, bus.total_cnt}, 0);
        check({tag, "_idx"}, {bus.test_num, bus.label_addr}, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, c;
        bus.go = 1'b0;
        bus.abort = 1'b0;
        bus.first_idx = '0;
        bus.last_idx = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // four samples, index 2 misclassified, one ignored go mid-batch
        s0 = start_cnt; d0 = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i));
        start_batch(10'd0, 10'd3);
        repeat (3) @(negedge clk);
        bus.first_idx = 10'd7; bus.last_idx = 10'd9; bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        wait_done("s1", 400, c);
        @(negedge clk);
        check("s1_total", bus.total_cnt, 4);
        check("s1_correct", bus.correct_cnt, 3);
        check("s1_starts", start_cnt - s0, 4);
        check("s1_dones", done_cnt - d0, 1);
        check("s1_busy", bus.busy, 0);
        repeat (5) @(negedge clk);
        check("s1_hold_total", bus.total_cnt, 4);
        check("s1_hold_correct", bus.correct_cnt, 3);

        // empty batch
        s0 = start_cnt; d0 = done_cnt;
        start_batch(10'd5, 10'd4);
        wait_done("s2", 10, c);
        check("s2_done_latency_ok", c + 1 <= 2, 1);
        @(negedge clk);
        check("s2_starts", start_cnt - s0, 0);
        check("s2_dones", done_cnt - d0, 1);
        check("s2_cnts", {bus.total_cnt, bus.correct_cnt}, 0);

        // top index, no wrap
        s0 = start_cnt; d0 = done_cnt;
        exp_q.push_back(10'd1023);
        start_batch(10'd1023, 10'd1023);
        wait_done("s3", 200, c);
        @(negedge clk);
        check("s3_starts", start_cnt - s0, 1);
        check("s3_total", bus.total_cnt, 1);
        check("s3_correct", bus.correct_cnt, 1);
        check("s3_test_num", bus.test_num, 1023);
        check("s3_state", dbg_state, ST_IDLE);

        // abort in WAIT of the second sample, then a stray done
        s0 = start_cnt; d0 = done_cnt;
        exp_q.push_back(10'd0); exp_q.push_back(10'd1);
        start_batch(10'd0, 10'd3);
        wait_state("s4", ST_WAIT, 2, s0, 300);
        pulse_abort();
        check("s4_state", dbg_state, ST_IDLE);
        check("s4_busy", bus.busy, 0);
        check("s4_total", bus.total_cnt, 1);
        inject_req++;
        repeat (20) @(negedge clk);
        check("s4_state_after_done", dbg_state, ST_IDLE);
        check("s4_total_after_done", bus.total_cnt, 1);
        check("s4_correct_after_done", bus.correct_cnt, 1);
        check("s4_dones", done_cnt - d0, 0);
        check("s4_starts", start_cnt - s0, 2);

        // MLP never answers for index 1
        s0 = start_cnt; d0 = done_cnt;
        skip_idx = 1;
`ifdef MLP_TIMEOUT_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(10'(i));
        start_batch(10'd0, 10'd2);
        wait_done("s5", 500, c);
        @(negedge clk);
        check("s5_timeout_err", bus.timeout_err, 1);
        check("s5_total", bus.total_cnt, 3);
        check("s5_correct", bus.correct_cnt, 1);
        check("s5_dones", done_cnt - d0, 1);
`else
        exp_q.push_back(10'd0); exp_q.push_back(10'd1);
        start_batch(10'd0, 10'd2);
        repeat (80) @(negedge clk);
        check("s5_stuck_state", dbg_state, ST_WAIT);
        check("s5_busy", bus.busy, 1);
        check("s5_timeout_err", bus.timeout_err, 0);
        check("s5_total", bus.total_cnt, 1);
        pulse_abort();
        check("s5_aborted", dbg_state, ST_IDLE);
`endif
        skip_idx = -1;

        // reset in COMPARE, then a clean batch
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(i));
        start_batch(10'd0, 10'd3);
        wait_state("s6", ST_COMPARE, 1, s0, 100);
        rst = 1'b1;
        #1;
        check_all_zero("s6_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(10'd0); exp_q.push_back(10'd1);
        start_batch(10'd0, 10'd1);
        wait_done("s6", 200, c);
        @(negedge clk);
        check("s6_total", bus.total_cnt, 2);
        check("s6_correct", bus.correct_cnt, 2);
        check("s6_timeout_err", bus.timeout_err, 0);
        check("s6_exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
